dec_sel_seq: RTL and testbench
==============================

Name: dec_sel_seq

Overview:
- Registered, parametrised successor to the team's 3-to-8 gated decoder (74x138 style).
- Decodes an SEL_W-bit select into 2**SEL_W one-hot outputs, with output polarity chosen by parameter.
- Adds a HOLD mode, which latches a select, and a SWEEP mode, which auto-walks the outputs with a programmable dwell time.
- Used for chip-select and row/strobe sequencing next to the existing combinational decoder netlists.

Parameters:
SEL_W, 3, select width; output count NOUT = 2**SEL_W
DWELL_W, 4, width of the dwell counter and of the dwell input
ACTIVE_LOW, 1, 1: asserted output = 0 and inactive = all ones; 0: asserted = 1 and inactive = all zeros

Ports:
clk_pad  input  1  single clock; all state changes on rising edge
rst_pad  input  1  reset, synchronous, active-high
sel_pad  input  SEL_W  select, sampled on load
en_pad  input  1  active-high gate (G1 equivalent)
en_n_pad  input  2  active-low gates (G2A/G2B equivalent)
mode_pad  input  1  sampled on load; 0 = HOLD, 1 = SWEEP
dwell_pad  input  DWELL_W  extra cycles per output in SWEEP, sampled on load
load_pad  input  1  start/restart pulse
stop_pad  input  1  return to IDLE
out_pad  output  NOUT  registered decoded outputs
busy_pad  output  1  registered; 1 when state != IDLE
wrap_pad  output  1  registered one-cycle pulse when the SWEEP index wraps from NOUT-1 to 0

Behaviour:
- gate = en_pad & ~en_n_pad[0] & ~en_n_pad[1], evaluated combinationally each cycle.
- Registers:
  - state ∈ {IDLE, HOLD, SWEEP}
  - idx[SEL_W]
  - cnt[DWELL_W]
  - dwell_r[DWELL_W]
  - out_pad, busy_pad, wrap_pad
- Reset (rst_pad=1 at an edge, overrides everything, including mid-sweep):
  - state=IDLE, idx=0, cnt=0, dwell_r=0.
  - out_pad inactive (all ones if ACTIVE_LOW, else all zeros).
  - busy_pad=0, wrap_pad=0.
- Priority per edge: rst_pad > stop_pad > load_pad > normal advance.
- stop_pad=1:
  - state=IDLE, out_pad inactive next cycle, idx and dwell_r retained.
  - stop_pad together with load_pad: stop wins, load ignored.
- load_pad=1 (from any state):
  - idx=sel_pad, dwell_r=dwell_pad, cnt=dwell_pad.
  - state=HOLD if mode_pad=0, else SWEEP.
- IDLE: no counting; out_pad inactive.
- HOLD: idx constant.
- SWEEP, when gate=1 and no load/stop:
  - cnt != 0: cnt decrements.
  - cnt == 0: cnt=dwell_r and idx=idx+1 mod NOUT.
  - If idx was NOUT-1, wrap_pad=1 for exactly the next cycle; otherwise wrap_pad=0.
  - Each output is therefore asserted for dwell_r+1 cycles; dwell_r=0 advances every cycle.
- SWEEP with gate=0: idx and cnt frozen (clock-enable semantics); no wrap pulse.
- Output register, every edge:
  - out_pad = decode(idx_next) when state_next != IDLE and gate=1; otherwise inactive.
  - decode = single bit idx asserted per the ACTIVE_LOW polarity.
  - Latency: load at edge k makes decode(sel) visible from cycle k+1. A gate change at edge k takes effect on out_pad at k+1.
- busy_pad = (state_next != IDLE), registered.
- Exactly one out_pad bit is asserted whenever out_pad is not inactive; there are no glitch states between registers.
- Width rules: idx wraps naturally at SEL_W bits; cnt never underflows (reloaded at 0).

Decomposition:
- Shared package dec_pkg holds:
  - state enum (IDLE=2'd0, HOLD=2'd1, SWEEP=2'd2)
  - a function returning the inactive vector for a given NOUT and ACTIVE_LOW
- One sub-module, dec_onehot: purely combinational SEL_W to NOUT one-hot decoder with polarity parameter; instantiated once on idx_next.
- The top block holds the FSM, the counters and the output registers.

Test Plan:
- Reset: rst_pad=1 for 2 cycles with load_pad=1 -> out_pad=8'hFF, busy_pad=0, wrap_pad=0.
- HOLD:
  - en_pad=1, en_n_pad=0, mode=0, sel=5, load pulse -> next cycle out_pad=8'hDF, busy=1.
  - Then en_n_pad=2'b01 -> next cycle 8'hFF; clear it -> 8'hDF again.
- SWEEP dwell=0:
  - sel=6, load -> out sequence 8'hBF, 8'h7F, 8'hFE, 8'hFD.
  - wrap_pad=1 only in the cycle out becomes 8'hFE.
- SWEEP dwell=2, sel=0:
  - each of 8'hFE, 8'hFD held exactly 3 cycles.
  - Drop en_pad for 4 cycles mid-dwell -> out 8'hFF and the index resumes with the same remaining count.
- Simultaneous stop_pad and load_pad in SWEEP -> next cycle out_pad=8'hFF, busy=0; a later load with sel=3, mode=0 -> 8'hF7.
- Parameter build SEL_W=4, ACTIVE_LOW=0:
  - sweep dwell=0 from sel=15 -> out 16'h8000 then 16'h0001 with wrap_pad=1.
  - rst_pad mid-sweep -> 16'h0000.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the registered select decoder.
//   state_t      : sequencer state encoding (IDLE / HOLD / SWEEP)
//   MAX_NOUT     : widest output vector the helper function can describe
//   inactive_vec : the "nothing selected" pattern for a given output
//                  count and polarity, right-aligned in MAX_NOUT bits
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_NOUT  = 1 << MAX_SEL_W;

  // Active-low outputs idle at all ones, active-high outputs at all zeros.
  // Bits above nout are always zero so callers can slice the low nout bits.
  function automatic logic [MAX_NOUT-1:0] inactive_vec(input int nout,
                                                       input bit active_low);
    logic [MAX_NOUT-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_NOUT; i++) begin
      v[i] = active_low && (i < nout);
    end
    return v;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Purely combinational SEL_W-to-2**SEL_W one-hot decoder.
//   sel : binary select
//   out : exactly one bit asserted; asserted level is 0 when ACTIVE_LOW=1,
//         1 when ACTIVE_LOW=0
module dec_onehot #(
  parameter int SEL_W      = 3,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] out
);

  localparam int NOUT = 1 << SEL_W;

  logic [NOUT-1:0] hot;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hot      = '0;
    hot[sel] = 1'b1;
    out      = ACTIVE_LOW ? ~hot : hot;
  end

endmodule

// File: rtl/dec_sel_seq.sv
// Registered, gated select decoder with HOLD and SWEEP sequencing.
//   clk_pad   : clock, all state changes on the rising edge
//   rst_pad   : synchronous active-high reset
//   sel_pad   : select, captured on load
//   en_pad    : active-high gate
//   en_n_pad  : two active-low gates
//   mode_pad  : captured on load; 0 = HOLD, 1 = SWEEP
//   dwell_pad : extra cycles per output in SWEEP, captured on load
//   load_pad  : start / restart
//   stop_pad  : return to IDLE (wins over load)
//   out_pad   : registered decoded outputs
//   busy_pad  : registered, 1 while not IDLE
//   wrap_pad  : registered one-cycle pulse when SWEEP wraps NOUT-1 -> 0
module dec_sel_seq
  import dec_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_pad,
  input  logic                  rst_pad,
  input  logic [SEL_W-1:0]      sel_pad,
  input  logic                  en_pad,
  input  logic [1:0]            en_n_pad,
  input  logic                  mode_pad,
  input  logic [DWELL_W-1:0]    dwell_pad,
  input  logic                  load_pad,
  input  logic                  stop_pad,
  output logic [(1<<SEL_W)-1:0] out_pad,
  output logic                  busy_pad,
  output logic                  wrap_pad
);

  localparam int NOUT = 1 << SEL_W;
  localparam logic [MAX_NOUT-1:0] INACT_FULL = inactive_vec(NOUT, ACTIVE_LOW);
  localparam logic [NOUT-1:0]     INACTIVE   = INACT_FULL[NOUT-1:0];

  state_t             state, state_n;
  logic [SEL_W-1:0]   idx, idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_r, dwell_n;
  logic               wrap_n;
  logic               gate;
  logic [NOUT-1:0]    dec_out;

  assign gate = en_pad & ~en_n_pad[0] & ~en_n_pad[1];

  // Next-state logic. Priority: stop > load > sweep advance.
  // A closed gate acts as a clock enable on the sweep counters only.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    dwell_n = dwell_r;
    wrap_n  = 1'b0;
    if (stop_pad) begin
      state_n = IDLE;
    end else if (load_pad) begin
      idx_n   = sel_pad;
      dwell_n = dwell_pad;
      cnt_n   = dwell_pad;
      state_n = mode_pad ? SWEEP : HOLD;
    end else if (state == SWEEP && gate) begin
      if (cnt != '0) begin
        cnt_n = cnt - DWELL_W'(1);
      end else begin
        cnt_n  = dwell_r;
        idx_n  = idx + SEL_W'(1);
        wrap_n = (idx == {SEL_W{1'b1}});
      end
    end
  end

  // Decoding idx_n lets the output register show the new index in the
  // same cycle the index register takes it.
  dec_onehot #(
    .SEL_W      (SEL_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .sel (idx_n),
    .out (dec_out)
  );

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples the pre-edge values of all others.
  always_ff @(posedge clk_pad) begin
    if (rst_pad) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      dwell_r  <= '0;
      out_pad  <= INACTIVE;
      busy_pad <= 1'b0;
      wrap_pad <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      dwell_r  <= dwell_n;
      out_pad  <= (state_n != IDLE && gate) ? dec_out : INACTIVE;
      busy_pad <= (state_n != IDLE);
      wrap_pad <= wrap_n;
    end
  end

endmodule

// File: tb/tb_dec_sel_seq.sv
// Directed, table-driven bench for dec_sel_seq: one 3-bit active-low
// instance driven from a vector table, plus a 4-bit active-high instance
// exercised by a short hand-written sequence.
module tb_dec_sel_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-output, active-low instance
  logic       rst, stop, load, mode, en;
  logic [1:0] en_n;
  logic [2:0] sel;
  logic [3:0] dwell;
  logic [7:0] out8;
  logic       busy8, wrap8;

  dec_sel_seq #(.SEL_W(3), .DWELL_W(4), .ACTIVE_LOW(1'b1)) dut8 (
    .clk_pad   (clk),
    .rst_pad   (rst),
    .sel_pad   (sel),
    .en_pad    (en),
    .en_n_pad  (en_n),
    .mode_pad  (mode),
    .dwell_pad (dwell),
    .load_pad  (load),
    .stop_pad  (stop),
    .out_pad   (out8),
    .busy_pad  (busy8),
    .wrap_pad  (wrap8)
  );

  // 16-output, active-high instance
  logic        rst16, stop16, load16, mode16, en16;
  logic [1:0]  en_n16;
  logic [3:0]  sel16;
  logic [3:0]  dwell16;
  logic [15:0] out16;
  logic        busy16, wrap16;

  dec_sel_seq #(.SEL_W(4), .DWELL_W(4), .ACTIVE_LOW(1'b0)) dut16 (
    .clk_pad   (clk),
    .rst_pad   (rst16),
    .sel_pad   (sel16),
    .en_pad    (en16),
    .en_n_pad  (en_n16),
    .mode_pad  (mode16),
    .dwell_pad (dwell16),
    .load_pad  (load16),
    .stop_pad  (stop16),
    .out_pad   (out16),
    .busy_pad  (busy16),
    .wrap_pad  (wrap16)
  );

  typedef struct {
    logic       rst, stop, load, mode, en;
    logic [1:0] en_n;
    logic [2:0] sel;
    logic [3:0] dwell;
    logic [7:0] eo;
    logic       eb, ew;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(input logic r, input logic s, input logic l,
                             input logic m, input logic [2:0] se,
                             input logic [3:0] d, input logic e,
                             input logic [1:0] en2, input logic [7:0] eo,
                             input logic eb, input logic ew);
    vec_t x;
    x.rst = r; x.stop = s; x.load = l; x.mode = m; x.sel = se;
    x.dwell = d; x.en = e; x.en_n = en2; x.eo = eo; x.eb = eb; x.ew = ew;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; load = 1'b0; mode = 1'b0; en = 1'b1;
    en_n = 2'b00; sel = '0; dwell = '0;
    rst16 = 1'b1; stop16 = 1'b0; load16 = 1'b0; mode16 = 1'b0; en16 = 1'b1;
    en_n16 = 2'b00; sel16 = '0; dwell16 = '0;

    //              rst stp ld md sel dw en en_n  out   busy wrap
    // reset held with load asserted
    tbl.push_back(v(1, 0, 1, 0, 5, 0, 1, 2'b00, 8'hFF, 0, 0));
    tbl.push_back(v(1, 0, 1, 0, 5, 0, 1, 2'b00, 8'hFF, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFF, 0, 0));
    // HOLD sel=5 and gate toggling
    tbl.push_back(v(0, 0, 1, 0, 5, 0, 1, 2'b00, 8'hDF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b01, 8'hFF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hDF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 2'b00, 8'hFF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hDF, 1, 0));
    // SWEEP dwell=0 from sel=6, wrap into index 0
    tbl.push_back(v(0, 0, 1, 1, 6, 0, 1, 2'b00, 8'hBF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'h7F, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFE, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFD, 1, 0));
    // SWEEP dwell=2 from sel=0: three cycles per output
    tbl.push_back(v(0, 0, 1, 1, 0, 2, 1, 2'b00, 8'hFE, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFE, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFE, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFD, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFD, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFD, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFB, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFB, 1, 0));
    // en_pad low for 4 cycles mid-dwell: one dwell cycle remains after
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 2'b00, 8'hFF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 2'b00, 8'hFF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 2'b00, 8'hFF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 2'b00, 8'hFF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFB, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hF7, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hF7, 1, 0));
    // stop together with load: stop wins
    tbl.push_back(v(0, 1, 1, 0, 3, 0, 1, 2'b00, 8'hFF, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFF, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 3, 0, 1, 2'b00, 8'hF7, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 2'b00, 8'hFF, 0, 0));
    // load while gated off: busy but inactive, then visible
    tbl.push_back(v(0, 0, 1, 0, 7, 0, 1, 2'b10, 8'hFF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'h7F, 1, 0));
    // gate closed at index 7 suppresses the wrap until it reopens
    tbl.push_back(v(0, 0, 1, 1, 7, 0, 1, 2'b00, 8'h7F, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 2'b00, 8'hFF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFE, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 2'b00, 8'hFF, 0, 0));
    // reset mid-sweep returns to IDLE
    tbl.push_back(v(0, 0, 1, 1, 2, 0, 1, 2'b00, 8'hFB, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFF, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2'b00, 8'hFF, 0, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; stop = tbl[i].stop; load = tbl[i].load;
      mode = tbl[i].mode; sel = tbl[i].sel; dwell = tbl[i].dwell;
      en = tbl[i].en; en_n = tbl[i].en_n;
      step();
      check($sformatf("row%0d out", i),  32'(out8),  32'(tbl[i].eo));
      check($sformatf("row%0d busy", i), 32'(busy8), 32'(tbl[i].eb));
      check($sformatf("row%0d wrap", i), 32'(wrap8), 32'(tbl[i].ew));
    end
    rst = 1'b0; load = 1'b0; stop = 1'b0;

    // 16-output active-high build: sweep from 15 across the wrap, then reset
    rst16 = 1'b1;
    step();
    check("p16 reset out", 32'(out16), 32'h0000);
    check("p16 reset busy", 32'(busy16), 32'd0);
    rst16 = 1'b0; load16 = 1'b1; mode16 = 1'b1; sel16 = 4'd15; dwell16 = 4'd0;
    step();
    load16 = 1'b0;
    check("p16 load out", 32'(out16), 32'h8000);
    check("p16 load busy", 32'(busy16), 32'd1);
    check("p16 load wrap", 32'(wrap16), 32'd0);
    step();
    check("p16 wrap out", 32'(out16), 32'h0001);
    check("p16 wrap pulse", 32'(wrap16), 32'd1);
    step();
    check("p16 after wrap out", 32'(out16), 32'h0002);
    check("p16 after wrap pulse", 32'(wrap16), 32'd0);
    rst16 = 1'b1;
    step();
    check("p16 mid reset out", 32'(out16), 32'h0000);
    check("p16 mid reset busy", 32'(busy16), 32'd0);
    check("p16 mid reset wrap", 32'(wrap16), 32'd0);
    rst16 = 1'b0;
    step();
    check("p16 idle out", 32'(out16), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
